// File: rtl/fft_stage_sequencer.sv
// ============================================================================
// fft_stage_sequencer : stage/butterfly/twiddle command sequencer for an
// in-place radix-2 DIF FFT sharing one butterfly datapath across all stages.
// Optional macro FFT_SEQ_BITREV_EN adds a bit-reversed unload pass.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fft_stage_sequencer #(
    parameter int LOG2_N   = 6,
    parameter int PIPE_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              bf_valid,
    input  logic              bf_ready,
    output logic [LOG2_N-1:0] addr_a,
    output logic [LOG2_N-1:0] addr_b,
    output logic [5:0]        tw_sel,
`ifdef FFT_SEQ_BITREV_EN
    output logic              rd_valid,
    output logic [LOG2_N-1:0] rd_addr,
    input  logic              rd_ready,
`endif
    output logic [2:0]        stage
);

    localparam int         N          = 1 << LOG2_N;
    localparam logic [2:0] LAST_STAGE = 3'(LOG2_N - 1);
    localparam logic [3:0] DRAIN_LAST = 4'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_DRAIN  = 3'd2,
`ifdef FFT_SEQ_BITREV_EN
        ST_UNLOAD = 3'd3,
`endif
        ST_DONE   = 3'd4
    } state_t;

    state_t              state;
    logic [LOG2_N-2:0]   k;
    logic [3:0]          drain_cnt;
    logic                hs;
    logic                stage_end;
`ifdef FFT_SEQ_BITREV_EN
    logic [LOG2_N-1:0]   j;
`endif

    // Packs {addr_a, addr_b, tw_sel} for butterfly kk of stage s.
    function automatic logic [2*LOG2_N+5:0] bf_cmd(input logic [2:0] s,
                                                   input logic [LOG2_N-2:0] kk);
        logic [31:0] k32, span, pos, grp, a, tw;
        k32  = 32'(kk);
        span = 32'(N) >> (s + 3'd1);
        pos  = k32 & (span - 32'd1);
        grp  = k32 >> (LOG2_N - 1 - int'(s));
        a    = grp * 32'd2 * span + pos;
        tw   = pos << (int'(s) + 6 - LOG2_N);
        return {a[LOG2_N-1:0], a[LOG2_N-1:0] + span[LOG2_N-1:0], tw[5:0]};
    endfunction

`ifdef FFT_SEQ_BITREV_EN
    function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] v);
        logic [LOG2_N-1:0] r;
        for (int i = 0; i < LOG2_N; i++) r[i] = v[LOG2_N-1-i];
        return r;
    endfunction
`endif

    assign hs = bf_valid & bf_ready;

    // A stage finishes either on its last handshake (no pipeline) or at the end of drain.
    always_comb begin
        stage_end = 1'b0;
        if (state == ST_ISSUE && hs && (&k) && PIPE_LAT == 0) stage_end = 1'b1;
        if (state == ST_DRAIN && drain_cnt == DRAIN_LAST)      stage_end = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            bf_valid  <= 1'b0;
            addr_a    <= '0;
            addr_b    <= '0;
            tw_sel    <= '0;
            stage     <= '0;
            k         <= '0;
            drain_cnt <= '0;
`ifdef FFT_SEQ_BITREV_EN
            rd_valid  <= 1'b0;
            rd_addr   <= '0;
            j         <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_ISSUE;
                        busy     <= 1'b1;
                        bf_valid <= 1'b1;
                        k        <= '0;
                        stage    <= '0;
                        {addr_a, addr_b, tw_sel} <= bf_cmd(3'd0, '0);
                    end
                end
                ST_ISSUE: begin
                    if (hs) begin
                        if (!(&k)) begin
                            k <= k + 1'b1;
                            {addr_a, addr_b, tw_sel} <= bf_cmd(stage, k + 1'b1);
                        end else if (PIPE_LAT != 0) begin
                            state     <= ST_DRAIN;
                            bf_valid  <= 1'b0;
                            drain_cnt <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt != DRAIN_LAST) drain_cnt <= drain_cnt + 4'd1;
                end
`ifdef FFT_SEQ_BITREV_EN
                ST_UNLOAD: begin
                    if (rd_valid && rd_ready) begin
                        if (&j) begin
                            rd_valid <= 1'b0;
                            state    <= ST_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            j       <= j + 1'b1;
                            rd_addr <= bitrev(j + 1'b1);
                        end
                    end
                end
`endif
                ST_DONE: begin
                    state  <= ST_IDLE;
                    stage  <= '0;
                    addr_a <= '0;
                    addr_b <= '0;
                    tw_sel <= '0;
                end
                default: state <= ST_IDLE;
            endcase

            if (stage_end) begin
                if (stage != LAST_STAGE) begin
                    state    <= ST_ISSUE;
                    bf_valid <= 1'b1;
                    k        <= '0;
                    stage    <= stage + 3'd1;
                    {addr_a, addr_b, tw_sel} <= bf_cmd(stage + 3'd1, '0);
                end else begin
                    bf_valid <= 1'b0;
`ifdef FFT_SEQ_BITREV_EN
                    state    <= ST_UNLOAD;
                    rd_valid <= 1'b1;
                    rd_addr  <= '0;
                    j        <= '0;
`else
                    state    <= ST_DONE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
`endif
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer (default parameters, macro undefined).
`default_nettype none

module tb_fft_stage_sequencer;

    localparam int LOG2_N   = 6;
    localparam int PIPE_LAT = 4;
    localparam int HALF     = 32;
    localparam int NCMD     = LOG2_N * HALF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       bf_ready = 1'b0;
    logic       busy, done, bf_valid;
    logic [5:0] addr_a, addr_b, tw_sel;
    logic [2:0] stage;
`ifdef FFT_SEQ_BITREV_EN
    logic       rd_valid;
    logic [5:0] rd_addr;
    logic       rd_ready = 1'b1;
`endif

    fft_stage_sequencer #(.LOG2_N(LOG2_N), .PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .bf_valid(bf_valid), .bf_ready(bf_ready), .addr_a(addr_a), .addr_b(addr_b),
        .tw_sel(tw_sel),
`ifdef FFT_SEQ_BITREV_EN
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
`endif
        .stage(stage)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [2:0] s;
        logic [5:0] a;
        logic [5:0] b;
        logic [5:0] tw;
    } cmd_t;

    typedef struct {
        int s; int k; int a; int b; int tw;
    } vec_t;

    cmd_t        exp_q[$];
    cmd_t        log_cmd[NCMD];
    int          hs_idx = 0;
    int          n_chk = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          gap = 0;
    bit          mon_en = 1'b0;
    bit          prev_stall = 1'b0;
    logic [21:0] prev_cmd = '0;

    // Independent formulation: insert a zero bit at position p = LOG2_N-1-s into k.
    function automatic cmd_t model(int s, int k);
        int   p, lo, base;
        cmd_t c;
        p    = LOG2_N - 1 - s;
        lo   = k & ((1 << p) - 1);
        base = ((k >> p) << (p + 1)) | lo;
        c.s  = 3'(s);
        c.a  = 6'(base);
        c.b  = 6'(base | (1 << p));
        c.tw = 6'(lo << s);
        return c;
    endfunction

    task automatic check(string name, int got, int want);
        n_chk++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        cmd_t e;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (mon_en) begin
            if (prev_stall)
                check("stall_hold", int'({bf_valid, stage, addr_a, addr_b, tw_sel}), int'(prev_cmd));
            if (bf_valid && bf_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_cmd", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("cmd%0d", hs_idx), int'({stage, addr_a, addr_b, tw_sel}), int'(e));
                end
                if (hs_idx < NCMD) log_cmd[hs_idx] = {stage, addr_a, addr_b, tw_sel};
                hs_idx++;
            end
            if (!busy) gap = 0;
            else if (!bf_valid) gap++;
            else if (gap != 0) begin
                check("drain_gap", gap, PIPE_LAT);
                gap = 0;
            end
        end
        prev_stall = mon_en && bf_valid && !bf_ready;
        prev_cmd   = {bf_valid, stage, addr_a, addr_b, tw_sel};
    end

    task automatic push_expected();
        exp_q.delete();
        for (int s = 0; s < LOG2_N; s++)
            for (int k = 0; k < HALF; k++)
                exp_q.push_back(model(s, k));
        hs_idx = 0;
        gap    = 0;
    endtask

    task automatic run(bit rand_ready, bit inject);
        int c0, d0;
        bit got;
        push_expected();
        d0       = done_cnt;
        bf_ready = 1'b1;
        start    = 1'b1;
        c0       = cyc + 1;
        got      = 1'b0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(posedge clk); #1;
            if (done) begin
                got   = 1'b1;
                start = inject;  // asserted while in DONE: must be ignored
            end else begin
                start    = inject && busy && ($urandom_range(0, 15) == 0);
                bf_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        @(posedge clk); #1;
        start    = 1'b0;
        bf_ready = 1'b1;
        check("done_seen", int'(got), 1);
        if (!rand_ready) check("done_cycle", done_cyc - c0 + 1, 217);
        check("sb_empty", exp_q.size(), 0);
        check("handshakes", hs_idx, NCMD);
        repeat (3) @(posedge clk);
        #1;
        check("done_single", done_cnt - d0, 1);
        check("idle_after", int'({busy, bf_valid, done, stage}), 0);
        exp_q.delete();
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = '{0, 5, 5, 37, 5};
        vt[1] = '{1, 17, 33, 49, 2};
        vt[2] = '{2, 5, 5, 13, 20};
        vt[3] = '{5, 3, 6, 7, 0};
        vt[4] = '{0, 0, 0, 32, 0};
        vt[5] = '{5, 31, 62, 63, 0};
        vt[6] = '{3, 7, 11, 15, 24};
        vt[7] = '{4, 9, 17, 19, 16};

        // Reset held with start asserted
        rst_n = 1'b0;
        start = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("reset_outputs", int'({busy, done, bf_valid, stage, addr_a, addr_b, tw_sel}), 0);
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("no_start_from_reset", int'({busy, bf_valid}), 0);

        mon_en = 1'b1;
        run(1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            cmd_t c;
            c = log_cmd[vt[i].s * HALF + vt[i].k];
            check($sformatf("vec_s%0d_k%0d", vt[i].s, vt[i].k),
                  int'({c.s, c.a, c.b, c.tw}),
                  (vt[i].s << 18) | (vt[i].a << 12) | (vt[i].b << 6) | vt[i].tw);
        end

        run(1'b1, 1'b1);

        // Abort during stage 3
        begin
            int d0;
            push_expected();
            d0       = done_cnt;
            bf_ready = 1'b1;
            start    = 1'b1;
            for (int i = 0; i < 1000 && stage != 3'd3; i++) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
            start = 1'b0;
            check("reached_stage3", int'(stage), 3);
            repeat (5) @(posedge clk);
            #1;
            mon_en = 1'b0;
            rst_n  = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            check("abort_outputs", int'({busy, done, bf_valid, stage, addr_a, addr_b, tw_sel}), 0);
            repeat (300) @(posedge clk);
            #1;
            check("abort_no_done", done_cnt - d0, 0);
            check("abort_idle", int'({busy, bf_valid}), 0);
            exp_q.delete();
            mon_en = 1'b1;
        end

        run(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
